// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph patterns (active-low
// {g,f,e,d,c,b,a}), special display codes and a code classification helper.
package seg7_pkg;

   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0011000;
   localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
   localparam logic [6:0] GLYPH_ERR   = 7'b0000110;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_MINUS  = 4'd15;
   localparam logic [3:0] CODE_ERR_LO = 4'd10;
   localparam logic [3:0] CODE_ERR_HI = 4'd14;

   typedef enum logic {
      PH_BLANK,
      PH_LIT
   } slot_phase_e;

   function automatic logic is_err_code(input logic [3:0] code);
      return (code >= CODE_ERR_LO) && (code <= CODE_ERR_HI);
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational code-to-glyph map; a set blank flag forces all segments dark.
module seg7_glyph (
   input  logic [3:0] code,
   input  logic       blank,
   output logic [6:0] seg
);
   import seg7_pkg::*;

   always_comb begin
      seg = GLYPH_BLANK;
      if (!blank) begin
         case (code)
            4'd0:       seg = GLYPH_0;
            4'd1:       seg = GLYPH_1;
            4'd2:       seg = GLYPH_2;
            4'd3:       seg = GLYPH_3;
            4'd4:       seg = GLYPH_4;
            4'd5:       seg = GLYPH_5;
            4'd6:       seg = GLYPH_6;
            4'd7:       seg = GLYPH_7;
            4'd8:       seg = GLYPH_8;
            4'd9:       seg = GLYPH_9;
            CODE_MINUS: seg = GLYPH_MINUS;
            default:    seg = GLYPH_ERR;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver with a tear-free double
// buffer, per-slot blanking guard and optional leading-zero suppression.
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 2000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic                    load_i,
   input  logic                    lz_en_i,
   output logic [6:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o,
   output logic                    err_o
);
   import seg7_pkg::*;

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

   logic [DIV_W-1:0]        div;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] display;
   logic [4*NUM_DIGITS-1:0] pending;
   logic                    pend_flag;

   logic                    div_wrap;
   logic                    boundary;
   slot_phase_e             phase;
   logic [3:0]              disp_code [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [3:0]              cur_code;
   logic                    cur_blank;

   logic [6:0]              seg_p0;
   logic [NUM_DIGITS-1:0]   an_p0;
   logic                    frame_p0;
   logic                    err_p0;

   assign div_wrap = (div == DIV_LAST);
   assign boundary = div_wrap && (idx == IDX_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div <= '0;
         idx <= '0;
      end else if (div_wrap) begin
         div <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         div <= div + 1'b1;
      end
   end

   // A load landing on the boundary cycle bypasses pending so it is not a frame late.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         display   <= '0;
         pending   <= '0;
         pend_flag <= 1'b0;
      end else if (boundary) begin
         if (load_i) begin
            display <= digits_i;
         end else if (pend_flag) begin
            display <= pending;
         end
         pend_flag <= 1'b0;
      end else if (load_i) begin
         pending   <= digits_i;
         pend_flag <= 1'b1;
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
         disp_code[k] = display[4*k +: 4];
      end
   end

   // Walk down from the top digit; suppression stops at the first nonzero code.
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      lz_mask    = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero && (disp_code[k] == 4'd0);
         lz_mask[k] = lz_en_i && upper_zero;
      end
   end

   always_comb begin
      err_p0 = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (is_err_code(disp_code[k])) begin
            err_p0 = 1'b1;
         end
      end
   end

   assign phase     = (div < BLANK_END) ? PH_BLANK : PH_LIT;
   assign cur_code  = disp_code[idx];
   assign cur_blank = (phase == PH_BLANK) || lz_mask[idx];

   seg7_glyph u_glyph (
      .code  (cur_code),
      .blank (cur_blank),
      .seg   (seg_p0)
   );

   assign an_p0    = (phase == PH_BLANK) ? '1 : ~(NUM_DIGITS'(1) << idx);
   assign frame_p0 = (idx == '0) && (div == '0);

   // Stage 1: registered pins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_o   <= GLYPH_BLANK;
         an_o    <= '1;
         frame_o <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         seg_o   <= seg_p0;
         an_o    <= an_p0;
         frame_o <= frame_p0;
         err_o   <= err_p0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-clock slots, 1 blank clock.
module tb_seg7_scan_driver;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G6 = 7'b0000010;
   localparam logic [6:0] G7 = 7'b1111000;
   localparam logic [6:0] G8 = 7'b0000000;
   localparam logic [6:0] G9 = 7'b0011000;
   localparam logic [6:0] GM = 7'b0111111;
   localparam logic [6:0] GE = 7'b0000110;
   localparam logic [6:0] GB = 7'b1111111;

   // segs packs the expected glyphs as {digit3, digit2, digit1, digit0}
   typedef struct packed {
      logic [15:0] digits;
      logic        lz;
      logic [27:0] segs;
      logic        err;
   } vec_t;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic [15:0] digits_i = 16'h0000;
   logic        load_i   = 1'b0;
   logic        lz_en_i  = 1'b0;
   logic [6:0]  seg_o;
   logic [3:0]  an_o;
   logic        frame_o;
   logic        err_o;

   int npass  = 0;
   int ntotal = 0;
   int fidx   = 0;

   seg7_scan_driver #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (4),
      .BLANK_CYCLES (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .digits_i (digits_i),
      .load_i   (load_i),
      .lz_en_i  (lz_en_i),
      .seg_o    (seg_o),
      .an_o     (an_o),
      .frame_o  (frame_o),
      .err_o    (err_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One full frame starting at its frame_o sample; optional loads at slot-clock sa/sb (0 = none).
   task automatic run_frame(input vec_t e, input int sa, input logic [15:0] da,
                            input int sb, input logic [15:0] db);
      logic [15:0] want;
      tick();
      check($sformatf("f%0d_start", fidx), {4'h0, frame_o, an_o, seg_o}, {4'h0, 1'b1, 4'hF, GB});
      check($sformatf("f%0d_err", fidx), {15'h0, err_o}, {15'h0, e.err});
      lz_en_i = e.lz;
      for (int s = 1; s < 16; s++) begin
         load_i   = (s == sa) || (s == sb);
         digits_i = (s == sb) ? db : da;
         tick();
         if (s % 4 == 0) want = {4'h0, 1'b0, 4'hF, GB};
         else want = {4'h0, 1'b0, ~(4'b0001 << (s / 4)), e.segs[(s / 4) * 7 +: 7]};
         check($sformatf("f%0d_s%0d", fidx, s), {4'h0, frame_o, an_o, seg_o}, want);
      end
      load_i = 1'b0;
      fidx++;
   endtask

   initial begin
      vec_t v [10];
      vec_t z0;
      vec_t d2;
      vec_t d3;

      z0   = {16'h0000, 1'b0, {G0, G0, G0, G0}, 1'b0};
      d2   = {16'h2222, 1'b0, {G2, G2, G2, G2}, 1'b0};
      d3   = {16'h3333, 1'b0, {G3, G3, G3, G3}, 1'b0};
      v[0] = {16'h1234, 1'b0, {G1, G2, G3, G4}, 1'b0};
      v[1] = {16'h0070, 1'b1, {GB, GB, G7, G0}, 1'b0};
      v[2] = {16'h0070, 1'b0, {G0, G0, G7, G0}, 1'b0};
      v[3] = {16'hF00B, 1'b0, {GM, G0, G0, GE}, 1'b1};
      v[4] = {16'hF00B, 1'b1, {GM, G0, G0, GE}, 1'b1};
      v[5] = {16'h0000, 1'b1, {GB, GB, GB, G0}, 1'b0};
      v[6] = {16'h0000, 1'b0, {G0, G0, G0, G0}, 1'b0};
      v[7] = {16'h8965, 1'b0, {G8, G9, G6, G5}, 1'b0};
      v[8] = {16'h00A7, 1'b1, {GB, GB, GE, G7}, 1'b1};
      v[9] = {16'h0800, 1'b1, {GB, G8, G0, G0}, 1'b0};

      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_hold%0d", i), {3'h0, err_o, frame_o, an_o, seg_o},
               {3'h0, 1'b0, 1'b0, 4'hF, GB});
      end
      reset = 1'b0;

      // Each frame shows the previous load and issues the next one mid-frame.
      run_frame(z0, 6, v[0].digits, 0, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         run_frame(v[i], (i < 9) ? 6 : 0, (i < 9) ? v[(i + 1) % 10].digits : 16'h0000, 0, 16'h0000);
      end

      run_frame(v[9], 3, 16'h1111, 9, 16'h2222);
      run_frame(d2, 15, 16'h3333, 0, 16'h0000);
      run_frame(d3, 0, 16'h0000, 0, 16'h0000);

      for (int s = 0; s < 10; s++) begin
         load_i   = (s == 4);
         digits_i = 16'h5555;
         tick();
      end
      load_i = 1'b0;
      check("pre_rst_lit", {4'h0, frame_o, an_o, seg_o}, {4'h0, 1'b0, 4'b1011, G3});
      reset = 1'b1;
      #1;
      check("rst_async", {3'h0, err_o, frame_o, an_o, seg_o}, {3'h0, 1'b0, 1'b0, 4'hF, GB});
      tick();
      tick();
      check("rst_mid_hold", {3'h0, err_o, frame_o, an_o, seg_o}, {3'h0, 1'b0, 1'b0, 4'hF, GB});
      reset = 1'b0;
      run_frame(z0, 0, 16'h0000, 0, 16'h0000);
      run_frame(z0, 0, 16'h0000, 0, 16'h0000);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
